can_tx_mailbox: RTL and testbench
=================================

# can_tx_mailbox

Parametrised multi-mailbox transmit scheduler for the CAN controller. Holds NUM_MBOX frames (11-bit identifier, DLC, up to 8 data bytes) and always offers the highest-priority pending frame (lowest identifier) to the `can_tx` engine through a request/acknowledge handshake. After arbitration loss it re-selects; after a bus error it retries up to a limit. It replaces the single fixed `address` and `transmit_data` source feeding `can_tx`, and runs on the same `clk` as `can_tx`.

## Interface
- NUM_MBOX, 4: number of mailboxes (2..16); SW = clog2(NUM_MBOX)
- RETRY_LIMIT, 16: error retries allowed per frame before it is dropped (1..255)
- clk  in  1  system clock (Clock_gen output)
- RESET  in  1  reset, asynchronous, active-high
- wr_en  in  1  load mailbox wr_sel with wr_id/wr_dlc/wr_data
- wr_sel  in  SW  target mailbox
- wr_id  in  11  frame identifier
- wr_dlc  in  4  data length code, raw
- wr_data  in  64  payload; byte 0 = [63:56]
- abort  in  NUM_MBOX  per-mailbox cancel request, level
- tx_ack  in  1  engine accepted the offered frame; 1-cycle pulse
- tx_done  in  1  frame sent and ACKed; 1-cycle pulse
- tx_arb_lost  in  1  arbitration lost; 1-cycle pulse
- tx_error  in  1  bus/ACK error; 1-cycle pulse
- tx_req  out  1  frame offered to engine
- tx_id  out  11, tx_dlc  out  4, tx_data  out  64  offered frame
- pending  out  NUM_MBOX  mailbox holds an unsent frame
- done_pulse  out  NUM_MBOX  1-cycle pulse, frame sent
- fail_pulse  out  NUM_MBOX  1-cycle pulse, retry limit exhausted
- wr_rej  out  1  1-cycle pulse, write to the active mailbox ignored
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, SELECT, REQ, ACTIVE.
- IDLE: if `pending` is non-zero, go to SELECT.
- SELECT: register the winner, cur, which is the pending mailbox with the lowest id; ties go to the lowest index. Mailboxes with abort asserted are excluded. If no candidate remains, return to IDLE. Otherwise go to REQ.
- REQ: tx_req=1. tx_id, tx_dlc and tx_data come from registers and are stable while tx_req is high. tx_ack moves to ACTIVE.
- REQ with abort[cur]: clear pending[cur], drop tx_req next cycle, go to IDLE. No pulse.
- ACTIVE: tx_req=0. Wait for a result. If several results arrive in the same cycle, tx_done beats tx_error, and tx_error beats tx_arb_lost.
  - tx_done: clear pending[cur]; pulse done_pulse[cur]; go to IDLE.
  - tx_error: increment retry[cur]. If the new count exceeds RETRY_LIMIT, clear pending[cur] and pulse fail_pulse[cur]. Go to IDLE.
  - tx_arb_lost: retry count unchanged; go to IDLE (re-arbitrate).
  - abort[cur] seen during ACTIVE is latched. At an error or arb_lost result it clears pending[cur] with no pulse. tx_done still wins and gives done_pulse.
- Payload: tx_data bytes at index ≥ min(dlc,8) are forced to 0. tx_dlc passes the raw value (9..15 means 8 bytes).
- Write to a non-active mailbox: overwrite it, set pending, clear its retry count. An abort on that mailbox in the same cycle loses to the write.
- Write to cur while in REQ or ACTIVE: ignored, wr_rej pulses.
- abort on a non-active pending mailbox: clears pending next cycle.
- Retry counters: 8 bits per mailbox; they do not wrap.

## Timing
- Reset (async): state=IDLE; pending, retry counters, tx_req, tx_id, tx_dlc, tx_data, done_pulse, fail_pulse, wr_rej and busy all go to 0 immediately.
- Reset mid-frame: the frame is discarded and no pulse is issued.
- wr_en at cycle n:
  - pending[sel]=1 at n+1.
  - busy=1 at n+2 (SELECT).
  - tx_req=1 at n+3, if the block was IDLE.
- tx_ack at cycle m: tx_req=0 at m+1.
- Result pulse at cycle k:
  - pending, done_pulse and fail_pulse update at k+1.
  - State is IDLE at k+1.
  - Next tx_req at k+3 at the earliest.
- done_pulse and fail_pulse are exactly one cycle wide and never both set for the same mailbox.
- Pulses on tx_ack, tx_done, tx_arb_lost or tx_error that arrive outside the state that expects them are ignored.

## Test plan
- Reset, then write mbox0 (id 0x25, dlc 2, data 0xAABB…). Required: tx_req at n+3 with tx_data=0xAABB000000000000. After ack then done: done_pulse=4'b0001, pending=0.
- Load mbox1 (id 0x100) and mbox3 (id 0x010) in the same IDLE window. Required: mbox3 offered first, then mbox1. Equal ids in mbox0 and mbox2: mbox0 first.
- Active mbox1 (id 0x100) gets tx_arb_lost while mbox2 (id 0x005) is written during ACTIVE. Required: mbox2 is offered next, and the retry count of mbox1 is unchanged.
- RETRY_LIMIT=2, with tx_error after every ack. Required: three attempts, then fail_pulse[cur] and pending cleared.
- Abort in REQ: tx_req drops with no pulse. Abort in ACTIVE followed by tx_done: done_pulse. Abort in ACTIVE followed by tx_error: silent clear. Write to cur in ACTIVE: wr_rej=1 and the mailbox contents are unchanged.
- Assert RESET in ACTIVE with 3 mailboxes pending. Required: all outputs 0 immediately and no pulses afterwards.

Source files
------------

// File: rtl/can_tx_mailbox.sv
// Multi-mailbox CAN transmit scheduler: holds NUM_MBOX frames and offers the
// lowest-identifier pending frame to can_tx, with retry and abort handling.
module can_tx_mailbox #(
  parameter int NUM_MBOX    = 4,
  parameter int RETRY_LIMIT = 16,
  localparam int SW = $clog2(NUM_MBOX)
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                wr_en,
  input  logic [SW-1:0]       wr_sel,
  input  logic [10:0]         wr_id,
  input  logic [3:0]          wr_dlc,
  input  logic [63:0]         wr_data,
  input  logic [NUM_MBOX-1:0] abort,
  input  logic                tx_ack,
  input  logic                tx_done,
  input  logic                tx_arb_lost,
  input  logic                tx_error,
  output logic                tx_req,
  output logic [10:0]         tx_id,
  output logic [3:0]          tx_dlc,
  output logic [63:0]         tx_data,
  output logic [NUM_MBOX-1:0] pending,
  output logic [NUM_MBOX-1:0] done_pulse,
  output logic [NUM_MBOX-1:0] fail_pulse,
  output logic                wr_rej,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  // Handshake: tx_req stays high with a stable frame until tx_ack is seen in
  // REQ; exactly one result pulse (done/error/arb_lost) is then consumed in ACTIVE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_REQ    = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       cur_q, cur_d;
  logic                abort_lat_q, abort_lat_d;
  logic [NUM_MBOX-1:0] pending_q, pending_d;
  logic [7:0]          retry_q [NUM_MBOX];
  logic [7:0]          retry_d [NUM_MBOX];
  logic [10:0]         id_q    [NUM_MBOX];
  logic [10:0]         id_d    [NUM_MBOX];
  logic [3:0]          dlc_q   [NUM_MBOX];
  logic [3:0]          dlc_d   [NUM_MBOX];
  logic [63:0]         data_q  [NUM_MBOX];
  logic [63:0]         data_d  [NUM_MBOX];
  logic                tx_req_q, tx_req_d;
  logic [10:0]         tx_id_q, tx_id_d;
  logic [3:0]          tx_dlc_q, tx_dlc_d;
  logic [63:0]         tx_data_q, tx_data_d;
  logic [NUM_MBOX-1:0] done_pulse_q, done_pulse_d;
  logic [NUM_MBOX-1:0] fail_pulse_q, fail_pulse_d;
  logic                wr_rej_q, wr_rej_d;

  logic [NUM_MBOX-1:0] cur_oh;
  logic [NUM_MBOX-1:0] clr;
  logic                abort_cur;
  logic                owned;
  logic                sel_found;
  logic [SW-1:0]       sel_idx;
  logic [10:0]         sel_id;
  logic [3:0]          sel_dlc;
  logic [63:0]         sel_data;
  logic [63:0]         sel_data_masked;
  logic [7:0]          retry_cur;
  logic [8:0]          retry_inc;
  logic                exhausted;

  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < NUM_MBOX; i++) cur_oh[i] = (cur_q == SW'(i));
    abort_cur = |(abort & cur_oh);
    owned     = (state_q == S_REQ) || (state_q == S_ACTIVE);

    // Lowest id wins; strict compare keeps the lowest index on ties.
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    sel_dlc   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_MBOX; i++) begin
      if (pending_q[i] && !abort[i] && (!sel_found || id_q[i] < sel_id)) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
        sel_id    = id_q[i];
        sel_dlc   = dlc_q[i];
        sel_data  = data_q[i];
      end
    end
    // Byte b survives only when b < dlc; dlc 9..15 keeps all eight bytes.
    sel_data_masked = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < sel_dlc) sel_data_masked[63-8*b -: 8] = sel_data[63-8*b -: 8];
    end

    retry_cur = '0;
    for (int i = 0; i < NUM_MBOX; i++) if (cur_oh[i]) retry_cur = retry_q[i];
    retry_inc = {1'b0, retry_cur} + 9'd1;
    exhausted = retry_inc > 9'(RETRY_LIMIT);
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    abort_lat_d  = abort_lat_q;
    retry_d      = retry_q;
    id_d         = id_q;
    dlc_d        = dlc_q;
    data_d       = data_q;
    tx_req_d     = tx_req_q;
    tx_id_d      = tx_id_q;
    tx_dlc_d     = tx_dlc_q;
    tx_data_d    = tx_data_q;
    done_pulse_d = '0;
    fail_pulse_d = '0;
    wr_rej_d     = 1'b0;
    clr          = '0;
    pending_d    = pending_q;

    case (state_q)
      S_IDLE: begin
        if (|pending_q) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (sel_found) begin
          cur_d       = sel_idx;
          tx_id_d     = sel_id;
          tx_dlc_d    = sel_dlc;
          tx_data_d   = sel_data_masked;
          tx_req_d    = 1'b1;
          abort_lat_d = 1'b0;
          state_d     = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An ack in the same cycle as abort wins: the engine already owns the
        // frame, so the abort is carried into ACTIVE instead.
        if (tx_ack) begin
          tx_req_d    = 1'b0;
          abort_lat_d = abort_cur;
          state_d     = S_ACTIVE;
        end else if (abort_cur) begin
          tx_req_d = 1'b0;
          clr      = cur_oh;
          state_d  = S_IDLE;
        end
      end
      S_ACTIVE: begin
        abort_lat_d = abort_lat_q | abort_cur;
        if (tx_done) begin
          clr          = cur_oh;
          done_pulse_d = cur_oh;
          state_d      = S_IDLE;
        end else if (tx_error) begin
          for (int i = 0; i < NUM_MBOX; i++) begin
            if (cur_oh[i]) retry_d[i] = retry_inc[8] ? 8'hFF : retry_inc[7:0];
          end
          if (abort_lat_q || abort_cur) begin
            clr = cur_oh;
          end else if (exhausted) begin
            clr          = cur_oh;
            fail_pulse_d = cur_oh;
          end
          state_d = S_IDLE;
        end else if (tx_arb_lost) begin
          if (abort_lat_q || abort_cur) clr = cur_oh;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NUM_MBOX; i++) begin
      if (abort[i] && !(owned && cur_oh[i])) clr[i] = 1'b1;
    end
    pending_d = pending_q & ~clr;

    // A write lands after aborts so that it wins over a same-cycle abort.
    for (int i = 0; i < NUM_MBOX; i++) begin
      if (wr_en && wr_sel == SW'(i)) begin
        if (owned && cur_oh[i]) begin
          wr_rej_d = 1'b1;
        end else begin
          id_d[i]      = wr_id;
          dlc_d[i]     = wr_dlc;
          data_d[i]    = wr_data;
          retry_d[i]   = '0;
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      abort_lat_q  <= 1'b0;
      pending_q    <= '0;
      tx_req_q     <= 1'b0;
      tx_id_q      <= '0;
      tx_dlc_q     <= '0;
      tx_data_q    <= '0;
      done_pulse_q <= '0;
      fail_pulse_q <= '0;
      wr_rej_q     <= 1'b0;
      for (int i = 0; i < NUM_MBOX; i++) begin
        retry_q[i] <= '0;
        id_q[i]    <= '0;
        dlc_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      abort_lat_q  <= abort_lat_d;
      pending_q    <= pending_d;
      tx_req_q     <= tx_req_d;
      tx_id_q      <= tx_id_d;
      tx_dlc_q     <= tx_dlc_d;
      tx_data_q    <= tx_data_d;
      done_pulse_q <= done_pulse_d;
      fail_pulse_q <= fail_pulse_d;
      wr_rej_q     <= wr_rej_d;
      for (int i = 0; i < NUM_MBOX; i++) begin
        retry_q[i] <= retry_d[i];
        id_q[i]    <= id_d[i];
        dlc_q[i]   <= dlc_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  assign tx_req     = tx_req_q;
  assign tx_id      = tx_id_q;
  assign tx_dlc     = tx_dlc_q;
  assign tx_data    = tx_data_q;
  assign pending    = pending_q;
  assign done_pulse = done_pulse_q;
  assign fail_pulse = fail_pulse_q;
  assign wr_rej     = wr_rej_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_can_tx_mailbox.sv
// Self-checking bench for can_tx_mailbox: timing/payload vector table, hand
// sequences for abort/retry/reset corners, and a randomized model comparison.
module tb_can_tx_mailbox;

  localparam int NM = 4;
  localparam int RL = 2;

  logic          clk;
  logic          RESET;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [10:0]   wr_id;
  logic [3:0]    wr_dlc;
  logic [63:0]   wr_data;
  logic [NM-1:0] abort;
  logic          tx_ack, tx_done, tx_arb_lost, tx_error;
  logic          tx_req;
  logic [10:0]   tx_id;
  logic [3:0]    tx_dlc;
  logic [63:0]   tx_data;
  logic [NM-1:0] pending, done_pulse, fail_pulse;
  logic          wr_rej, busy;
  logic [1:0]    dbg_state;

  can_tx_mailbox #(.NUM_MBOX(NM), .RETRY_LIMIT(RL)) dut (
    .clk(clk), .RESET(RESET), .wr_en(wr_en), .wr_sel(wr_sel), .wr_id(wr_id),
    .wr_dlc(wr_dlc), .wr_data(wr_data), .abort(abort), .tx_ack(tx_ack),
    .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_error(tx_error),
    .tx_req(tx_req), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .pending(pending), .done_pulse(done_pulse), .fail_pulse(fail_pulse),
    .wr_rej(wr_rej), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [63:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  // model state for the randomized phase
  logic [10:0]   m_id   [NM];
  logic [3:0]    m_dlc  [NM];
  logic [63:0]   m_data [NM];
  int            m_retry[NM];
  logic [NM-1:0] m_pend;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic wr(input int sel, input logic [10:0] id, input logic [3:0] dlc,
                    input logic [63:0] data);
    wr_en = 1'b1; wr_sel = 2'(sel); wr_id = id; wr_dlc = dlc; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic ack();
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
  endtask

  task automatic result(input bit d, input bit e, input bit a);
    tx_done = d; tx_error = e; tx_arb_lost = a;
    step();
    tx_done = 1'b0; tx_error = 1'b0; tx_arb_lost = 1'b0;
  endtask

  task automatic pulse_abort(input logic [NM-1:0] m);
    abort = m;
    step();
    abort = '0;
  endtask

  task automatic wait_req(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  task automatic quiet(input string nm, input int n);
    logic [NM-1:0] seen_p;
    logic          seen_r;
    seen_p = '0;
    seen_r = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      seen_p = seen_p | done_pulse | fail_pulse;
      seen_r = seen_r | tx_req;
    end
    chk({nm, "_pulses"}, 64'(seen_p), 64'd0);
    chk({nm, "_req"}, 64'(seen_r), 64'd0);
  endtask

  function automatic logic [63:0] mask_payload(input logic [63:0] d, input logic [3:0] dlc);
    int n;
    n = (dlc > 4'd8) ? 8 : int'(dlc);
    if (n == 0) return 64'd0;
    return d & ~((64'd1 << (64 - 8 * n)) - 64'd1);
  endfunction

  initial begin
    bit ok;
    int attempts;
    int best;
    int s;
    int nw;
    int r;
    logic [NM-1:0] exp_done, exp_fail;
    logic [10:0]   nid;
    logic [10:0]   exp_id;

    RESET = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_id = '0; wr_dlc = '0; wr_data = '0;
    abort = '0; tx_ack = 1'b0; tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;

    vecs[0] = '{4'd0,  64'h1122334455667788, 64'h0000000000000000};
    vecs[1] = '{4'd2,  64'hAABBCCDDEEFF0011, 64'hAABB000000000000};
    vecs[2] = '{4'd5,  64'h1122334455667788, 64'h1122334455000000};
    vecs[3] = '{4'd8,  64'h1122334455667788, 64'h1122334455667788};
    vecs[4] = '{4'd12, 64'hCAFEBABEDEADBEEF, 64'hCAFEBABEDEADBEEF};
    vecs[5] = '{4'd1,  64'hFFFFFFFFFFFFFFFF, 64'hFF00000000000000};

    step(); step(); step();
    chk("rst_tx_req", 64'(tx_req), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    RESET = 1'b0;
    step();

    // exact latency of the first frame
    wr(0, 11'h025, 4'd2, 64'hAABBCCDDEEFF0011);
    chk("n1_pending", 64'(pending), 64'h1);
    chk("n1_busy", 64'(busy), 64'd0);
    step();
    chk("n2_busy", 64'(busy), 64'd1);
    chk("n2_tx_req", 64'(tx_req), 64'd0);
    step();
    chk("n3_tx_req", 64'(tx_req), 64'd1);
    chk("n3_tx_id", 64'(tx_id), 64'h025);
    chk("n3_tx_dlc", 64'(tx_dlc), 64'd2);
    chk("n3_tx_data", tx_data, 64'hAABB000000000000);
    ack();
    chk("ack_drop_req", 64'(tx_req), 64'd0);
    result(1'b1, 1'b0, 1'b0);
    chk("done_pulse0", 64'(done_pulse), 64'h1);
    chk("done_pending", 64'(pending), 64'd0);
    chk("done_idle", 64'(busy), 64'd0);
    step();
    chk("done_one_cycle", 64'(done_pulse), 64'd0);

    // payload masking table
    foreach (vecs[v]) begin
      wr(0, 11'h0A0 + 11'(v), vecs[v].dlc, vecs[v].data);
      wait_req($sformatf("vec%0d_req", v), ok);
      chk($sformatf("vec%0d_data", v), tx_data, vecs[v].exp_data);
      chk($sformatf("vec%0d_dlc", v), 64'(tx_dlc), 64'(vecs[v].dlc));
      ack();
      result(1'b1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_done", v), 64'(done_pulse), 64'h1);
    end

    // priority by id, then by index
    wr(1, 11'h100, 4'd1, 64'h0);
    wr(3, 11'h010, 4'd1, 64'h0);
    wait_req("prio_req_a", ok);
    chk("prio_first_id", 64'(tx_id), 64'h010);
    ack(); result(1'b1, 1'b0, 1'b0);
    chk("prio_first_done", 64'(done_pulse), 64'b1000);
    wait_req("prio_req_b", ok);
    chk("prio_second_id", 64'(tx_id), 64'h100);
    ack(); result(1'b1, 1'b0, 1'b0);
    chk("prio_second_done", 64'(done_pulse), 64'b0010);
    wr(2, 11'h077, 4'd0, 64'h0);
    wr(0, 11'h077, 4'd0, 64'h0);
    wait_req("tie_req_a", ok);
    ack(); result(1'b1, 1'b0, 1'b0);
    chk("tie_first_mbox0", 64'(done_pulse), 64'b0001);
    wait_req("tie_req_b", ok);
    ack(); result(1'b1, 1'b0, 1'b0);
    chk("tie_second_mbox2", 64'(done_pulse), 64'b0100);

    // arbitration loss re-selects; retries then exhaust at RL+1 attempts
    wr(1, 11'h100, 4'd0, 64'h0);
    wait_req("arb_req", ok);
    ack();
    wr(2, 11'h005, 4'd0, 64'h0);
    chk("arb_wr_not_rej", 64'(wr_rej), 64'd0);
    result(1'b0, 1'b0, 1'b1);
    chk("arb_pending", 64'(pending), 64'b0110);
    wait_req("arb_reselect_req", ok);
    chk("arb_reselect_id", 64'(tx_id), 64'h005);
    ack(); result(1'b1, 1'b0, 1'b0);
    chk("arb_mbox2_done", 64'(done_pulse), 64'b0100);
    attempts = 0;
    exp_fail = '0;
    for (int i = 0; i < 6; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        if (tx_req) ok = 1'b1;
        else step();
      end
      if (!ok) break;
      attempts++;
      ack();
      result(1'b0, 1'b1, 1'b0);
      if (fail_pulse != '0) begin
        exp_fail = fail_pulse;
        break;
      end
    end
    chk("retry_attempts", 64'(attempts), 64'(RL + 1));
    chk("retry_fail_pulse", 64'(exp_fail), 64'b0010);
    chk("retry_pending", 64'(pending), 64'd0);

    // abort in REQ
    wr(3, 11'h033, 4'd0, 64'h0);
    wait_req("abreq_req", ok);
    pulse_abort(4'b1000);
    chk("abreq_req_drop", 64'(tx_req), 64'd0);
    chk("abreq_pending", 64'(pending), 64'd0);
    quiet("abreq_quiet", 5);
    chk("abreq_idle", 64'(busy), 64'd0);

    // abort in ACTIVE then done
    wr(0, 11'h044, 4'd0, 64'h0);
    wait_req("abact_req", ok);
    ack();
    pulse_abort(4'b0001);
    chk("abact_still_pending", 64'(pending), 64'b0001);
    result(1'b1, 1'b0, 1'b0);
    chk("abact_done_pulse", 64'(done_pulse), 64'b0001);
    chk("abact_done_pending", 64'(pending), 64'd0);

    // abort in ACTIVE then error: silent
    wr(0, 11'h045, 4'd0, 64'h0);
    wait_req("aberr_req", ok);
    ack();
    pulse_abort(4'b0001);
    result(1'b0, 1'b1, 1'b0);
    chk("aberr_pending", 64'(pending), 64'd0);
    chk("aberr_pulses", 64'(done_pulse | fail_pulse), 64'd0);
    quiet("aberr_quiet", 5);

    // write to the active mailbox is rejected; abort on another pending one
    wr(1, 11'h111, 4'd8, 64'h0102030405060708);
    wait_req("wrcur_req", ok);
    ack();
    wr(1, 11'h222, 4'd3, 64'hFFFFFFFFFFFFFFFF);
    chk("wrcur_rej", 64'(wr_rej), 64'd1);
    wr(3, 11'h300, 4'd0, 64'h0);
    chk("wrother_not_rej", 64'(wr_rej), 64'd0);
    pulse_abort(4'b1000);
    chk("abort_other_pending", 64'(pending), 64'b0010);
    result(1'b0, 1'b0, 1'b1);
    wait_req("wrcur_reoffer_req", ok);
    chk("wrcur_id_kept", 64'(tx_id), 64'h111);
    chk("wrcur_data_kept", tx_data, 64'h0102030405060708);
    ack(); result(1'b1, 1'b0, 1'b0);
    chk("wrcur_done", 64'(done_pulse), 64'b0010);

    // reset in ACTIVE with three mailboxes pending
    wr(0, 11'h010, 4'd8, 64'h1111111111111111);
    wr(1, 11'h020, 4'd8, 64'h2222222222222222);
    wr(2, 11'h030, 4'd8, 64'h3333333333333333);
    wait_req("rstact_req", ok);
    ack();
    chk("rstact_pending", 64'(pending), 64'b0111);
    #3 RESET = 1'b1;
    #1;
    chk("rstact_pending0", 64'(pending), 64'd0);
    chk("rstact_busy0", 64'(busy), 64'd0);
    chk("rstact_tx0", {52'(tx_id), 4'(tx_dlc), 8'(tx_req)}, 64'd0);
    chk("rstact_data0", tx_data, 64'd0);
    chk("rstact_pulse0", 64'({done_pulse, fail_pulse, wr_rej}), 64'd0);
    step();
    RESET = 1'b0;
    step();
    result(1'b1, 1'b0, 1'b0);
    quiet("rstact_quiet", 6);
    chk("rstact_pending_after", 64'(pending), 64'd0);

    // randomized phase against a frame-level model
    m_pend = '0;
    for (int i = 0; i < NM; i++) begin
      m_id[i] = '0; m_dlc[i] = '0; m_data[i] = '0; m_retry[i] = 0;
    end
    for (int it = 0; it < 80; it++) begin
      if (m_pend == '0) begin
        s = $urandom_range(0, NM - 1);
        nid = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 15)) : 11'($urandom_range(0, 2047));
        m_id[s] = nid; m_dlc[s] = 4'($urandom_range(0, 15));
        m_data[s] = {$urandom, $urandom}; m_retry[s] = 0; m_pend[s] = 1'b1;
        wr(s, m_id[s], m_dlc[s], m_data[s]);
      end
      best = -1;
      for (int i = 0; i < NM; i++) begin
        if (m_pend[i] && (best < 0 || m_id[i] < m_id[best])) best = i;
      end
      exp_q.push_back(m_id[best]);
      wait_req("rnd_req", ok);
      if (!ok) break;
      exp_id = exp_q.pop_front();
      chk("rnd_id", 64'(tx_id), 64'(exp_id));
      chk("rnd_dlc", 64'(tx_dlc), 64'(m_dlc[best]));
      chk("rnd_data", tx_data, mask_payload(m_data[best], m_dlc[best]));
      ack();
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        s = $urandom_range(0, NM - 1);
        nid = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 15)) : 11'($urandom_range(0, 2047));
        wr(s, nid, 4'($urandom_range(0, 15)), {$urandom, $urandom});
        if (s == best) begin
          chk("rnd_wr_rej", 64'(wr_rej), 64'd1);
        end else begin
          chk("rnd_wr_ok", 64'(wr_rej), 64'd0);
          m_id[s] = wr_id; m_dlc[s] = wr_dlc; m_data[s] = wr_data;
          m_retry[s] = 0; m_pend[s] = 1'b1;
        end
      end
      r = $urandom_range(1, 7);
      result(r[0], r[1], r[2]);
      exp_done = '0;
      exp_fail = '0;
      if (r[0]) begin
        m_pend[best] = 1'b0;
        exp_done[best] = 1'b1;
      end else if (r[1]) begin
        m_retry[best]++;
        if (m_retry[best] > RL) begin
          m_pend[best] = 1'b0;
          exp_fail[best] = 1'b1;
        end
      end
      chk("rnd_done_pulse", 64'(done_pulse), 64'(exp_done));
      chk("rnd_fail_pulse", 64'(fail_pulse), 64'(exp_fail));
      chk("rnd_pending", 64'(pending), 64'(m_pend));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
